// File: rtl/inert_pkg.sv
// Shared constants and types for the inertial-sensor SPI responder.
package inert_pkg;

  // Register addresses (7-bit address field of the command byte)
  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
  localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H      = 7'h2D;

  // Bit 15 of the received frame selects read (1) or write (0)
  localparam int RW_BIT = 15;

  // Frame length and command-byte length, sized for the 5-bit bit counter
  localparam logic [4:0] FRAME_LEN = 5'd16;
  localparam logic [4:0] CMD_BITS  = 5'd8;

  // Frame-level states of the serial engine
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_resp_phy.sv
// Serial engine of the responder: synchronizes the SPI pins, counts bits,
// shifts the incoming frame in and the read byte out, and reports frame end.
//
// Handshake: frame_end is a one-clk pulse on the synchronized SS_n rise of
// an open frame; wr_done / rd_done qualify it for complete 16-bit frames and
// frame_addr / frame_data are stable during that pulse. tx_data is sampled
// on the SCLK fall that follows the 8th rise, addressed by cmd_addr.
module spi_resp_phy
  import inert_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic [6:0] cmd_addr,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_end,
  output logic       wr_done,
  output logic       rd_done,
  output state_t     state
);

  logic        ss_ff1, ss_ff2, ss_ff3;
  logic        sclk_ff1, sclk_ff2, sclk_ff3;
  logic        mosi_ff1, mosi_ff2;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic        frame_ok;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_shft;
  logic [7:0]  tx_shft;
  state_t      state_nxt;

  // Synchronize the asynchronous pins; third flops give edge detection.
  // SS_n and SCLK idle high, so they reset high to avoid false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff1   <= 1'b1;
      ss_ff2   <= 1'b1;
      ss_ff3   <= 1'b1;
      sclk_ff1 <= 1'b1;
      sclk_ff2 <= 1'b1;
      sclk_ff3 <= 1'b1;
      mosi_ff1 <= 1'b0;
      mosi_ff2 <= 1'b0;
    end else begin
      ss_ff1   <= ss_n;
      ss_ff2   <= ss_ff1;
      ss_ff3   <= ss_ff2;
      sclk_ff1 <= sclk;
      sclk_ff2 <= sclk_ff1;
      sclk_ff3 <= sclk_ff2;
      mosi_ff1 <= mosi;
      mosi_ff2 <= mosi_ff1;
    end
  end

  assign ss_fall   = ss_ff3 & ~ss_ff2;
  assign ss_rise   = ~ss_ff3 & ss_ff2;
  assign sclk_rise = ~sclk_ff3 & sclk_ff2;
  assign sclk_fall = sclk_ff3 & ~sclk_ff2;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; frame_end fires on the SS_n rise of an open frame
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: if (ss_fall) state_nxt = ST_CMD;
      ST_CMD: begin
        if (ss_rise) begin
          state_nxt = ST_DONE;
          frame_end = 1'b1;
        end else if (sclk_rise && (bit_cnt == CMD_BITS - 5'd1)) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ss_rise) begin
          state_nxt = ST_DONE;
          frame_end = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_ok = (bit_cnt == FRAME_LEN);
  assign wr_done  = frame_end & frame_ok & ~rx_shft[RW_BIT];
  assign rd_done  = frame_end & frame_ok & rx_shft[RW_BIT];

  // Receive shifter and bit counter; counter saturates so over-long
  // frames can never wrap back to a valid length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_shft <= '0;
    end else if (state == ST_IDLE || state == ST_DONE) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      rx_shft <= {rx_shft[14:0], mosi_ff2};
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Transmit shifter: load the read byte on the first fall of the data
  // phase, then shift one bit per later fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '0;
    end else if (state == ST_DATA && sclk_fall) begin
      if (bit_cnt == CMD_BITS) tx_shft <= tx_data;
      else                     tx_shft <= {tx_shft[6:0], 1'b0};
    end
  end

  assign miso       = (state == ST_DATA) ? tx_shft[7] : 1'b0;
  assign cmd_addr   = rx_shft[6:0];
  assign frame_addr = rx_shft[14:8];
  assign frame_data = rx_shft[7:0];

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial-sensor SPI responder: register file, coherent sample buffer and
// data-ready interrupt on top of the serial engine.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter logic [7:0] INT_CFG_VAL  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] az,
  output logic        NEMO_setup
);

  logic [7:0]  rdata;
  logic [6:0]  cmd_addr, frame_addr;
  logic [7:0]  frame_data;
  logic        frame_end, wr_done, rd_done;
  state_t      phy_state;

  logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g;
  logic [15:0] ptch_q, az_q, pend_ptch, pend_az;
  logic        pend_vld;
  logic        frame_active;
  logic        commit;
  logic [15:0] commit_ptch, commit_az;
  logic        int_q;

  spi_resp_phy u_phy (
    .clk        (clk),
    .rst_n      (rst_n),
    .ss_n       (SS_n),
    .sclk       (SCLK),
    .mosi       (MOSI),
    .tx_data    (rdata),
    .miso       (MISO),
    .cmd_addr   (cmd_addr),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .frame_end  (frame_end),
    .wr_done    (wr_done),
    .rd_done    (rd_done),
    .state      (phy_state)
  );

  // Read mux addressed by the command byte; unmapped addresses read zero
  always_comb begin
    rdata = 8'h00;
    case (cmd_addr)
      ADDR_WHO_AM_I:  rdata = WHO_AM_I_VAL;
      ADDR_INT1_CTRL: rdata = int1_ctrl;
      ADDR_CTRL1_XL:  rdata = ctrl1_xl;
      ADDR_CTRL2_G:   rdata = ctrl2_g;
      ADDR_PTCH_L:    rdata = ptch_q[7:0];
      ADDR_PTCH_H:    rdata = ptch_q[15:8];
      ADDR_AZ_L:      rdata = az_q[7:0];
      ADDR_AZ_H:      rdata = az_q[15:8];
      default:        rdata = 8'h00;
    endcase
  end

  // Writable registers; read-only and unmapped targets are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_ctrl <= '0;
      ctrl1_xl  <= '0;
      ctrl2_g   <= '0;
    end else if (wr_done) begin
      case (frame_addr)
        ADDR_INT1_CTRL: int1_ctrl <= frame_data;
        ADDR_CTRL1_XL:  ctrl1_xl  <= frame_data;
        ADDR_CTRL2_G:   ctrl2_g   <= frame_data;
        default: ;
      endcase
    end
  end

  assign NEMO_setup = (int1_ctrl == INT_CFG_VAL);

  // A sample that arrives during a frame waits until the frame closes so a
  // master reading low then high bytes never sees a torn value. A strobe
  // coinciding with frame end is newer than anything pending and wins.
  assign frame_active = (phy_state == ST_CMD) || (phy_state == ST_DATA);

  always_comb begin
    commit      = 1'b0;
    commit_ptch = ptch_rt;
    commit_az   = az;
    if (frame_end) begin
      if (smpl_vld) begin
        commit = 1'b1;
      end else if (pend_vld) begin
        commit      = 1'b1;
        commit_ptch = pend_ptch;
        commit_az   = pend_az;
      end
    end else if (smpl_vld && !frame_active) begin
      commit = 1'b1;
    end
  end

  // Pending buffer: latest in-frame sample, released at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_ptch <= '0;
      pend_az   <= '0;
    end else if (frame_end) begin
      pend_vld <= 1'b0;
    end else if (smpl_vld && frame_active) begin
      pend_vld  <= 1'b1;
      pend_ptch <= ptch_rt;
      pend_az   <= az;
    end
  end

  // Visible sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_q <= '0;
      az_q   <= '0;
    end else if (commit) begin
      ptch_q <= commit_ptch;
      az_q   <= commit_az;
    end
  end

  // Data-ready flag: a fresh sample beats a same-cycle clearing read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  int_q <= 1'b0;
    else if (!NEMO_setup)                        int_q <= 1'b0;
    else if (commit)                             int_q <= 1'b1;
    else if (rd_done && frame_addr == ADDR_AZ_H) int_q <= 1'b0;
  end

  assign INT = int_q & NEMO_setup;

endmodule

// File: doc/inert_spi_resp.md
Name: inert_spi_resp

Overview:
- Synthesizable SPI responder emulating the inertial sensor that inert_intf talks to: 16-bit SPI frames, small register file, data-ready INT.
- Lets the FPGA build and the full-chip bench close the inert_intf loop without the behavioural Segway model.
- Sample data (pitch rate, AZ) is supplied by a physics/stimulus source through a strobe.

Parameters:
- WHO_AM_I_VAL, 8'h6A, value returned on a read of address 0x0F.
- INT_CFG_VAL, 8'h02, value of INT1_CTRL (0x0D) that enables the INT output.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- SS_n  input  1  slave select from master, async to clk
- SCLK  input  1  serial clock from master, async to clk
- MOSI  input  1  master-out data
- MISO  output  1  slave-out data
- INT  output  1  data-ready interrupt, active high
- smpl_vld  input  1  one-clk strobe: new sample available
- ptch_rt  input  16  pitch-rate sample
- az  input  16  Z-acceleration sample
- NEMO_setup  output  1  high once INT1_CTRL == INT_CFG_VAL

Behaviour:
- Reset: MISO=0, INT=0, NEMO_setup=0. INT1_CTRL=0, sample regs=0, bit count=0, shift regs=0.
- Sync: SS_n, SCLK and MOSI each pass through a 2-flop synchronizer. A third flop on SCLK gives rise/fall detect.
  - Required SCLK period ≥ 8 clk; SS_n setup to first SCLK fall ≥ 4 clk.
- Frame format: 16 bits, MSB first.
  - bit15 = R/W (1 = read).
  - bits14:8 = address.
  - bits7:0 = write data, or don't-care on a read.
  - Master changes MOSI on SCLK fall; both sides sample on SCLK rise.
- State machine:
  - IDLE: SS_n high. Bit count cleared.
  - CMD: on the SS_n fall → CMD. Each SCLK rise shifts MOSI into rx_shft[15:0] and increments the 5-bit count. After the 8th rise → DATA.
  - DATA: the SCLK fall with count==8 loads tx_shft with rdata[address]. Each later fall shifts tx_shft left by 1. MISO = tx_shft[7] in DATA, else 0.
  - DONE: on the SS_n rise.
    - If count==16 and R/W==0: write rx_shft[7:0] to the addressed register, same cycle.
    - Otherwise no write.
    - If count==16 and R/W==1: apply read side effects.
    - Return to IDLE.
- Register map:
  - 0x0F WHO_AM_I (read-only).
  - 0x0D INT1_CTRL (r/w).
  - 0x10 CTRL1_XL and 0x11 CTRL2_G (r/w storage only).
  - 0x22/0x23 ptch_rt low/high (read-only).
  - 0x2C/0x2D az low/high (read-only).
  - Unmapped address reads 8'h00. Writes to read-only or unmapped addresses are ignored.
- Aborted frame: SS_n rises with count≠16 → no write and no side effect. Count clears and the next frame starts clean.
- Samples:
  - smpl_vld outside a frame: latch ptch_rt/az on the next clk.
  - smpl_vld during a frame (SS_n low): hold the values in a pending buffer and commit at the SS_n rise. This keeps low/high bytes coherent.
  - A second smpl_vld while a sample is pending overwrites the pending buffer.
- INT:
  - Set on sample commit when NEMO_setup==1.
  - Cleared on a completed read of 0x2D.
  - Commit and clear in the same cycle → INT stays set; the new sample wins.
  - INT is 0 while NEMO_setup==0.
- NEMO_setup: combinational compare of INT1_CTRL to INT_CFG_VAL. It updates the cycle after the write commits.
- Reset mid-frame: everything returns to reset values immediately. The frame in progress is discarded.

Decomposition:
- Package inert_pkg holds:
  - the address constants (ADDR_WHO_AM_I, ADDR_INT1_CTRL, ADDR_CTRL1_XL, ADDR_CTRL2_G, ADDR_PTCH_L/H, ADDR_AZ_L/H);
  - the R/W bit index;
  - the frame-length constant 16;
  - the state enum typedef.
- One sub-module, spi_resp_phy, contains the synchronizers, edge detect, bit counter, rx/tx shifters and frame-done pulses. The top level holds the register file, sample buffer and INT logic.

Test Plan:
- Read WHO_AM_I: frame 16'h8F00 → MISO byte 8'h6A. No register changes; INT=0.
- Write INT1_CTRL: frame 16'h0D02 → NEMO_setup=1 within 2 clk of the SS_n rise. A readback frame 16'h8D00 returns 8'h02.
- Sample and INT: setup done, smpl_vld with ptch_rt=16'h1234 and az=16'hABCD.
  - INT=1.
  - Reads of 0x22/0x23 return 34/12. INT is still 1.
  - Read of 0x2C returns CD; read of 0x2D returns AB. INT=0 after the 0x2D frame.
- Sample mid-frame: pulse smpl_vld with 16'h5555 while reading 0x23 (old value 16'h1234).
  - The frame returns 12.
  - The next read of 0x23 returns 55.
- Aborted write: raise SS_n after 10 SCLKs of frame 16'h0D00 with NEMO_setup=1 → INT1_CTRL stays 02 and NEMO_setup stays 1. The next full read of 0x0F still returns 6A.
- Async reset mid-read (after 12 SCLKs) → MISO=0, INT=0, NEMO_setup=0 immediately. The first frame after release works normally.
